// File: rtl/vram_arbiter.sv
// N-client arbiter for the single-port VRAM. Client 0 (video) always wins; the rest share
// the remaining cycles by round-robin or fixed priority. Reads return after one cycle.
module vram_arbiter #(
   parameter int unsigned NUM_CLIENTS = 3,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter bit          RR_ENABLE   = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset_i,
   input  logic [NUM_CLIENTS-1:0]        req_i,
   input  logic [NUM_CLIENTS-1:0]        wr_i,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] addr_i,
   input  logic [NUM_CLIENTS*DATA_W-1:0] data_i,
   output logic [NUM_CLIENTS-1:0]        ack_o,
   output logic [NUM_CLIENTS-1:0]        rd_valid_o,
   output logic [NUM_CLIENTS*DATA_W-1:0] rd_data_o,
   output logic                          vram_sel_o,
   output logic                          vram_wr_o,
   output logic [ADDR_W-1:0]             vram_addr_o,
   output logic [DATA_W-1:0]             vram_data_o,
   input  logic [DATA_W-1:0]             vram_data_i
);

   localparam int unsigned IdW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   typedef logic [IdW-1:0] id_t;

   logic                   grant;
   id_t                    winner;
   logic                   other_found;
   id_t                    other_id;
   logic [NUM_CLIENTS-1:0] ack;
   logic [NUM_CLIENTS-1:0] rd_valid;
   logic                   pend_q;
   id_t                    pend_id_q;
   logic [DATA_W-1:0]      hold_q [NUM_CLIENTS];

   // Selection among clients 1..N-1; client 0 is handled separately below.
   generate
      if (NUM_CLIENTS == 1) begin : g_single
         assign other_found = 1'b0;
         assign other_id    = '0;
      end else if (RR_ENABLE) begin : g_rr
         localparam id_t LastId = id_t'(NUM_CLIENTS - 1);
         id_t rr_ptr_q;

         always_comb begin
            id_t cand;
            other_found = 1'b0;
            other_id    = '0;
            cand        = rr_ptr_q;
            for (int off = 1; off < int'(NUM_CLIENTS); off++) begin
               cand = (cand == LastId) ? id_t'(1) : cand + id_t'(1);
               if (!other_found && req_i[cand]) begin
                  other_found = 1'b1;
                  other_id    = cand;
               end
            end
         end

         // Only grants to clients 1..N-1 move the pointer.
         always_ff @(posedge clk) begin
            if (reset_i) begin
               rr_ptr_q <= LastId;
            end else if (grant && !req_i[0]) begin
               rr_ptr_q <= other_id;
            end
         end
      end else begin : g_fixed
         always_comb begin
            other_found = 1'b0;
            other_id    = '0;
            for (int k = int'(NUM_CLIENTS) - 1; k >= 1; k--) begin
               if (req_i[k]) begin
                  other_found = 1'b1;
                  other_id    = id_t'(k);
               end
            end
         end
      end
   endgenerate

   always_comb begin
      grant  = 1'b0;
      winner = '0;
      if (!reset_i) begin
         if (req_i[0]) begin
            grant = 1'b1;
         end else if (other_found) begin
            grant  = 1'b1;
            winner = other_id;
         end
      end
   end

   always_comb begin
      ack         = '0;
      vram_wr_o   = 1'b0;
      vram_addr_o = '0;
      vram_data_o = '0;
      if (grant) begin
         ack[winner] = 1'b1;
      end
      for (int k = 0; k < int'(NUM_CLIENTS); k++) begin
         if (ack[k]) begin
            vram_wr_o   = wr_i[k];
            vram_addr_o = addr_i[k*ADDR_W +: ADDR_W];
            vram_data_o = data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign ack_o      = ack;
   assign vram_sel_o = grant;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         pend_q    <= 1'b0;
         pend_id_q <= '0;
         for (int k = 0; k < int'(NUM_CLIENTS); k++) begin
            hold_q[k] <= '0;
         end
      end else begin
         pend_q    <= grant && !vram_wr_o;
         pend_id_q <= winner;
         if (pend_q) begin
            hold_q[pend_id_q] <= vram_data_i;
         end
      end
   end

   // Reset in the return cycle discards the pending read.
   always_comb begin
      rd_valid = '0;
      if (pend_q && !reset_i) begin
         rd_valid[pend_id_q] = 1'b1;
      end
   end

   assign rd_valid_o = rd_valid;

   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k < int'(NUM_CLIENTS); k++) begin
         rd_data_o[k*DATA_W +: DATA_W] = rd_valid[k] ? vram_data_i : hold_q[k];
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed table-driven bench for vram_arbiter (3 clients) with a behavioural VRAM;
// a fixed-priority instance runs alongside for its grant pattern.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, wr;
   logic [15:0] a1, a2, d1;
   logic [47:0] addr, data;
   logic [2:0]  ack, rd_valid;
   logic [47:0] rd_data;
   logic        vram_sel, vram_wr;
   logic [15:0] vram_addr, vram_wdata;
   logic [15:0] vram_rdata;
   logic [2:0]  fp_ack, fp_rd_valid;
   logic [47:0] fp_rd_data;
   logic        fp_sel, fp_wr;
   logic [15:0] fp_addr, fp_wdata;
   logic [15:0] mem [65536];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign addr = {a2, a1, 16'h0010};
   assign data = {16'hD002, d1, 16'hD000};

   vram_arbiter #(.NUM_CLIENTS(3), .ADDR_W(16), .DATA_W(16), .RR_ENABLE(1'b1)) dut (
      .clk(clk), .reset_i(reset), .req_i(req), .wr_i(wr), .addr_i(addr), .data_i(data),
      .ack_o(ack), .rd_valid_o(rd_valid), .rd_data_o(rd_data), .vram_sel_o(vram_sel),
      .vram_wr_o(vram_wr), .vram_addr_o(vram_addr), .vram_data_o(vram_wdata),
      .vram_data_i(vram_rdata)
   );

   vram_arbiter #(.NUM_CLIENTS(3), .ADDR_W(16), .DATA_W(16), .RR_ENABLE(1'b0)) dut_fp (
      .clk(clk), .reset_i(reset), .req_i(req), .wr_i(wr), .addr_i(addr), .data_i(data),
      .ack_o(fp_ack), .rd_valid_o(fp_rd_valid), .rd_data_o(fp_rd_data), .vram_sel_o(fp_sel),
      .vram_wr_o(fp_wr), .vram_addr_o(fp_addr), .vram_data_o(fp_wdata),
      .vram_data_i(16'h0000)
   );

   // VRAM model: contents start as addr ^ 16'h5A5A, read data one cycle after select.
   initial begin
      vram_rdata = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
   end

   always @(posedge clk) begin
      if (vram_sel) begin
         if (vram_wr) mem[vram_addr] <= vram_wdata;
         else         vram_rdata     <= mem[vram_addr];
      end
   end

   typedef struct {
      logic        rst;
      logic [2:0]  req, wr;
      logic [15:0] a1, a2, d1;
      logic [2:0]  e_ack, e_fp, e_val;
      logic [33:0] e_bus;
      logic [47:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [2:0] rq, input logic [2:0] w,
                      input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] y1,
                      input logic [2:0] e_ack, input logic [2:0] e_fp, input logic [2:0] e_val,
                      input logic e_sel, input logic e_wr, input logic [15:0] e_addr,
                      input logic [15:0] e_data, input logic [47:0] e_rd);
      vec_t v;
      v.rst = rst; v.req = rq; v.wr = w; v.a1 = x1; v.a2 = x2; v.d1 = y1;
      v.e_ack = e_ack; v.e_fp = e_fp; v.e_val = e_val;
      v.e_bus = {e_sel, e_wr, e_addr, e_data};
      v.e_rd = e_rd;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   localparam logic [47:0] RdA = {16'h5A6A, 16'h5A7A, 16'h5A4A};
   localparam logic [47:0] RdB = {16'h5A6A, 16'hA5A5, 16'h5A4A};
   localparam logic [47:0] RdC = {16'h5A5A, 16'hA5A5, 16'h5A4A};

   initial begin
      // rst req    wr     a1        a2        d1        ack    fp     val   sel wr addr  data
      add(1, 3'b111, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b000, 3'b000, 3'b000, 0, 0, 16'h0000, 16'h0000, '0);
      add(0, 3'b111, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b001, 3'b001, 3'b000, 1, 0, 16'h0010, 16'hD000, '0);
      add(0, 3'b110, 3'b000, 16'h0020, 16'h0030, 16'hD001, 3'b010, 3'b010, 3'b001, 1, 0, 16'h0020, 16'hD001,
          {16'h0000, 16'h0000, 16'h5A4A});
      add(0, 3'b110, 3'b000, 16'h0020, 16'h0030, 16'hD001, 3'b100, 3'b010, 3'b010, 1, 0, 16'h0030, 16'hD002,
          {16'h0000, 16'h5A7A, 16'h5A4A});
      for (int i = 0; i < 2; i++) begin
         add(0, 3'b110, 3'b000, 16'h0020, 16'h0030, 16'hD001, 3'b010, 3'b010, 3'b100, 1, 0, 16'h0020, 16'hD001, RdA);
         add(0, 3'b110, 3'b000, 16'h0020, 16'h0030, 16'hD001, 3'b100, 3'b010, 3'b010, 1, 0, 16'h0030, 16'hD002, RdA);
      end
      add(0, 3'b010, 3'b010, 16'h1234, 16'h0030, 16'hA5A5, 3'b010, 3'b010, 3'b100, 1, 1, 16'h1234, 16'hA5A5, RdA);
      add(0, 3'b010, 3'b000, 16'h1234, 16'h0030, 16'hA5A5, 3'b010, 3'b010, 3'b000, 1, 0, 16'h1234, 16'hA5A5, RdA);
      add(0, 3'b100, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b100, 3'b100, 3'b010, 1, 0, 16'h0000, 16'hD002, RdB);
      add(0, 3'b000, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b000, 3'b000, 3'b100, 0, 0, 16'h0000, 16'h0000, RdC);
      add(0, 3'b000, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b000, 3'b000, 3'b000, 0, 0, 16'h0000, 16'h0000, RdC);
      add(0, 3'b101, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b001, 3'b001, 3'b000, 1, 0, 16'h0010, 16'hD000, RdC);
      for (int i = 0; i < 7; i++) begin
         add(0, 3'b101, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b001, 3'b001, 3'b001, 1, 0, 16'h0010, 16'hD000, RdC);
      end
      add(0, 3'b100, 3'b000, 16'h1234, 16'h0000, 16'hD001, 3'b100, 3'b100, 3'b001, 1, 0, 16'h0000, 16'hD002, RdC);
      add(0, 3'b010, 3'b000, 16'h0020, 16'h0000, 16'hD001, 3'b010, 3'b010, 3'b100, 1, 0, 16'h0020, 16'hD001, RdC);
      add(1, 3'b010, 3'b000, 16'h0020, 16'h0000, 16'hD001, 3'b000, 3'b000, 3'b000, 0, 0, 16'h0000, 16'h0000, RdC);
      add(0, 3'b000, 3'b000, 16'h0020, 16'h0000, 16'hD001, 3'b000, 3'b000, 3'b000, 0, 0, 16'h0000, 16'h0000, '0);
      add(0, 3'b110, 3'b000, 16'h0020, 16'h0030, 16'hD001, 3'b010, 3'b010, 3'b000, 1, 0, 16'h0020, 16'hD001, '0);
      add(0, 3'b000, 3'b000, 16'h0020, 16'h0030, 16'hD001, 3'b000, 3'b000, 3'b010, 0, 0, 16'h0000, 16'h0000,
          {16'h0000, 16'h5A7A, 16'h0000});

      // One reset edge before the table so holding registers are defined.
      reset = 1'b1; req = 3'b111; wr = '0; a1 = '0; a2 = '0; d1 = '0;
      @(negedge clk);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; req = vecs[i].req; wr = vecs[i].wr;
         a1 = vecs[i].a1; a2 = vecs[i].a2; d1 = vecs[i].d1;
         #1;
         chk($sformatf("row%0d ack", i), 64'(ack), 64'(vecs[i].e_ack));
         chk($sformatf("row%0d fp_ack", i), 64'(fp_ack), 64'(vecs[i].e_fp));
         chk($sformatf("row%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_val));
         chk($sformatf("row%0d vram_bus", i), 64'({vram_sel, vram_wr, vram_addr, vram_wdata}),
             64'(vecs[i].e_bus));
         chk($sformatf("row%0d rd_data", i), 64'(rd_data), 64'(vecs[i].e_rd));
         @(negedge clk);
      end

      // Back-to-back client 1 reads with a new address every cycle.
      for (int i = 0; i < 4; i++) begin
         reset = 1'b0; req = 3'b010; wr = '0; a1 = 16'h0100 + 16'(i);
         #1;
         chk($sformatf("b2b%0d ack", i), 64'(ack), 64'(3'b010));
         if (i > 0) begin
            chk($sformatf("b2b%0d rd_valid", i), 64'(rd_valid), 64'(3'b010));
            chk($sformatf("b2b%0d slice1", i), 64'(rd_data[31:16]),
                64'(16'(16'h0100 + 16'(i) - 16'd1) ^ 16'h5A5A));
         end
         @(negedge clk);
      end
      req = 3'b000;
      #1;
      chk("b2b_last rd_valid", 64'(rd_valid), 64'(3'b010));
      chk("b2b_last slice1", 64'(rd_data[31:16]), 64'(16'h0103 ^ 16'h5A5A));
      @(negedge clk);
      #1;
      chk("b2b_hold rd_valid", 64'(rd_valid), 64'(3'b000));
      chk("b2b_hold slice1", 64'(rd_data[31:16]), 64'(16'h0103 ^ 16'h5A5A));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
